// File: rtl/icache_dm_controller_if.sv
// Bus bundle between the I-cache controller and its neighbours: CPU fetch port,
// storage-array port and memory read port. The master modport is the controller side.
interface icache_dm_controller_if #(
   parameter int unsigned WORD_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32
);
   logic                  cpu_req;
   logic [ADDR_WIDTH-1:0] cpu_addr;
   logic                  cpu_ready;
   logic                  cpu_valid;
   logic [WORD_WIDTH-1:0] cpu_data;

   logic                  st_read;
   logic                  st_write;
   logic [ADDR_WIDTH-1:0] st_address;
   logic [WORD_WIDTH-1:0] st_write_block;
   logic                  st_hit;
   logic [WORD_WIDTH-1:0] st_read_data;

   logic                  mem_req;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_ack;
   logic [WORD_WIDTH-1:0] mem_data;

   modport master (
      input  cpu_req, cpu_addr, st_hit, st_read_data, mem_ack, mem_data,
      output cpu_ready, cpu_valid, cpu_data, st_read, st_write, st_address, st_write_block,
             mem_req, mem_addr
   );

   modport slave (
      output cpu_req, cpu_addr, st_hit, st_read_data, mem_ack, mem_data,
      input  cpu_ready, cpu_valid, cpu_data, st_read, st_write, st_address, st_write_block,
             mem_req, mem_addr
   );
endinterface

// File: rtl/icache_dm_controller.sv
// Direct-mapped I-cache controller: array lookup, memory fetch on miss, then refill.
// Define ICACHE_PERF_CNT_EN to add hit_count/miss_count performance counters.
module icache_dm_controller #(
   parameter int unsigned WORD_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned CNT_WIDTH  = 32
) (
   input logic                   clk,
   input logic                   reset_n,
   icache_dm_controller_if.master bus
`ifdef ICACHE_PERF_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0]  hit_count,
   output logic [CNT_WIDTH-1:0]  miss_count
`endif
);

   if (ADDR_WIDTH != 32 || CNT_WIDTH == 0) begin : g_bad_param
      $error("icache_dm_controller: ADDR_WIDTH must be 32 and CNT_WIDTH nonzero");
   end

   typedef enum logic [1:0] {StIdle, StLookup, StMemReq, StFill} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [WORD_WIDTH-1:0] fill_q, fill_d;
   logic [WORD_WIDTH-1:0] cpu_data_q, cpu_data_d;
   logic                  cpu_valid_q, cpu_valid_d;
   logic                  mem_req_q, mem_req_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         addr_q      <= '0;
         fill_q      <= '0;
         cpu_data_q  <= '0;
         cpu_valid_q <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         fill_q      <= fill_d;
         cpu_data_q  <= cpu_data_d;
         cpu_valid_q <= cpu_valid_d;
         mem_req_q   <= mem_req_d;
         mem_addr_q  <= mem_addr_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      fill_d      = fill_q;
      cpu_data_d  = cpu_data_q;
      cpu_valid_d = 1'b0;
      mem_req_d   = mem_req_q;
      mem_addr_d  = mem_addr_q;
      unique case (state_q)
         StIdle: begin
            if (bus.cpu_req) begin
               addr_d  = bus.cpu_addr;
               state_d = StLookup;
            end
         end
         StLookup: begin
            // st_read_data is only trusted on a hit; on a miss it may be X
            if (bus.st_hit) begin
               cpu_data_d  = bus.st_read_data;
               cpu_valid_d = 1'b1;
               state_d     = StIdle;
            end else begin
               mem_req_d  = 1'b1;
               mem_addr_d = addr_q;
               state_d    = StMemReq;
            end
         end
         StMemReq: begin
            if (bus.mem_ack) begin
               mem_req_d   = 1'b0;
               fill_d      = bus.mem_data;
               cpu_data_d  = bus.mem_data;
               cpu_valid_d = 1'b1;
               state_d     = StFill;
            end
         end
         StFill: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Strobes are gated by reset so the array never sees a stray access during reset
   assign bus.cpu_ready      = (state_q == StIdle);
   assign bus.st_read        = reset_n && (state_q == StIdle) && bus.cpu_req;
   assign bus.st_write       = reset_n && (state_q == StFill);
   assign bus.st_address     = (state_q == StIdle) ? bus.cpu_addr : addr_q;
   assign bus.st_write_block = fill_q;
   assign bus.cpu_valid      = cpu_valid_q;
   assign bus.cpu_data       = cpu_data_q;
   assign bus.mem_req        = mem_req_q;
   assign bus.mem_addr       = mem_addr_q;

`ifdef ICACHE_PERF_CNT_EN
   logic [CNT_WIDTH-1:0] hit_count_q, miss_count_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hit_count_q  <= '0;
         miss_count_q <= '0;
      end else if (state_q == StLookup) begin
         if (bus.st_hit) hit_count_q  <= hit_count_q + CNT_WIDTH'(1);
         else            miss_count_q <= miss_count_q + CNT_WIDTH'(1);
      end
   end

   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_icache_dm_controller.sv
// Directed bench for icache_dm_controller with a small direct-mapped array model.
module tb_icache_dm_controller;

   logic clk;
   logic reset_n;
   int   n_vec = 0;
   int   n_err = 0;

   icache_dm_controller_if #(.WORD_WIDTH(32), .ADDR_WIDTH(32)) bus ();

`ifdef ICACHE_PERF_CNT_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
`endif

   icache_dm_controller #(
      .WORD_WIDTH(32),
      .ADDR_WIDTH(32),
      .CNT_WIDTH (32)
   ) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .bus       (bus)
`ifdef ICACHE_PERF_CNT_EN
      ,
      .hit_count (hit_count),
      .miss_count(miss_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   // Array model: 64 lines, index addr[7:2], tag addr[31:8]; hit returned one cycle after read
   logic        arr_valid [64];
   logic [23:0] arr_tag   [64];
   logic [31:0] arr_data  [64];

   initial begin
      logic        rd, wr, hit;
      logic [31:0] a, wb;
      int          idx;
      for (int i = 0; i < 64; i++) begin
         arr_valid[i] = 1'b0;
         arr_tag[i]   = '0;
         arr_data[i]  = '0;
      end
      bus.st_hit       = 1'b0;
      bus.st_read_data = '0;
      forever begin
         @(negedge clk);
         rd = bus.st_read;
         wr = bus.st_write;
         a  = bus.st_address;
         wb = bus.st_write_block;
         @(posedge clk);
         #1;
         idx = int'(a[7:2]);
         hit = rd && arr_valid[idx] && (arr_tag[idx] == a[31:8]);
         bus.st_hit       = hit;
         bus.st_read_data = hit ? arr_data[idx] : 32'h0BAD_0BAD;
         if (wr) begin
            arr_valid[idx] = 1'b1;
            arr_tag[idx]   = a[31:8];
            arr_data[idx]  = wb;
         end
      end
   end

   // Called just after a rising edge with the DUT in IDLE; returns just after the edge
   // that brings the DUT back to IDLE.
   task automatic fetch(input logic [31:0] addr, input bit exp_hit, input int lat,
                        input logic [31:0] data, input bit hold);
      bus.cpu_req  = 1'b1;
      bus.cpu_addr = addr;
      @(negedge clk);
      check_eq("idle_ready", bus.cpu_ready, 1);
      check_eq("idle_st_read", bus.st_read, 1);
      check_eq("idle_st_addr", bus.st_address, addr);
      @(posedge clk); #1;
      if (!hold) bus.cpu_req = 1'b0;
      @(negedge clk);
      check_eq("lkp_ready", bus.cpu_ready, 0);
      check_eq("lkp_st_read", bus.st_read, 0);
      check_eq("lkp_valid", bus.cpu_valid, 0);
      check_eq("lkp_st_addr", bus.st_address, addr);
      @(posedge clk); #1;
      if (exp_hit) begin
         check_eq("hit_valid", bus.cpu_valid, 1);
         check_eq("hit_data", bus.cpu_data, data);
         check_eq("hit_mem_req", bus.mem_req, 0);
         check_eq("hit_ready", bus.cpu_ready, 1);
      end else begin
         for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            check_eq("wait_mem_req", bus.mem_req, 1);
            check_eq("wait_mem_addr", bus.mem_addr, addr);
            check_eq("wait_ready", bus.cpu_ready, 0);
            check_eq("wait_st_read", bus.st_read, 0);
            @(posedge clk); #1;
         end
         bus.mem_ack  = 1'b1;
         bus.mem_data = data;
         @(negedge clk);
         check_eq("ack_mem_req", bus.mem_req, 1);
         check_eq("ack_mem_addr", bus.mem_addr, addr);
         @(posedge clk); #1;
         bus.mem_ack  = 1'b0;
         bus.mem_data = ~data;
         @(negedge clk);
         check_eq("fill_valid", bus.cpu_valid, 1);
         check_eq("fill_data", bus.cpu_data, data);
         check_eq("fill_st_write", bus.st_write, 1);
         check_eq("fill_st_read", bus.st_read, 0);
         check_eq("fill_block", bus.st_write_block, data);
         check_eq("fill_st_addr", bus.st_address, addr);
         check_eq("fill_mem_req", bus.mem_req, 0);
         check_eq("fill_ready", bus.cpu_ready, 0);
         @(posedge clk); #1;
         check_eq("post_fill_valid", bus.cpu_valid, 0);
         check_eq("post_fill_st_write", bus.st_write, 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n      = 1'b0;
      bus.cpu_req  = 1'b1;
      bus.cpu_addr = 32'h0000_0040;
      bus.mem_ack  = 1'b0;
      bus.mem_data = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_st_read", bus.st_read, 0);
      check_eq("rst_st_write", bus.st_write, 0);
      check_eq("rst_ready", bus.cpu_ready, 1);
      check_eq("rst_valid", bus.cpu_valid, 0);
      check_eq("rst_mem_req", bus.mem_req, 0);
      check_eq("rst_cpu_data", bus.cpu_data, 0);
      check_eq("rst_mem_addr", bus.mem_addr, 0);
`ifdef ICACHE_PERF_CNT_EN
      check_eq("rst_hit_cnt", hit_count, 0);
      check_eq("rst_miss_cnt", miss_count, 0);
`endif
      bus.cpu_req = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Stray ack in IDLE is ignored
      bus.mem_ack  = 1'b1;
      bus.mem_data = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      @(negedge clk);
      check_eq("stray_mem_req", bus.mem_req, 0);
      check_eq("stray_valid", bus.cpu_valid, 0);
      check_eq("stray_ready", bus.cpu_ready, 1);
      @(posedge clk); #1;

      fetch(32'h0000_0010, 1'b0, 3, 32'hDEAD_BEEF, 1'b0);   // cold miss
      fetch(32'h0000_0010, 1'b1, 0, 32'hDEAD_BEEF, 1'b0);   // hit
      fetch(32'h0000_0110, 1'b0, 1, 32'h1234_5678, 1'b0);   // conflict evicts 0x10
      fetch(32'h0000_0010, 1'b0, 0, 32'hCAFE_F00D, 1'b0);   // miss again, 1-cycle memory
`ifdef ICACHE_PERF_CNT_EN
      check_eq("hit_count", hit_count, 1);
      check_eq("miss_count", miss_count, 3);
`endif

      // Held request through a miss, then accepted again in IDLE
      fetch(32'h0000_0200, 1'b0, 2, 32'h0BAD_F00D, 1'b1);
      fetch(32'h0000_0200, 1'b1, 0, 32'h0BAD_F00D, 1'b0);

      // Reset in the middle of a miss
      bus.cpu_req  = 1'b1;
      bus.cpu_addr = 32'h0000_0300;
      @(posedge clk); #1;
      bus.cpu_req = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("mid_mem_req", bus.mem_req, 1);
      #1;
      reset_n = 1'b0;
      #1;
      check_eq("mid_rst_mem_req", bus.mem_req, 0);
      check_eq("mid_rst_valid", bus.cpu_valid, 0);
      check_eq("mid_rst_st_write", bus.st_write, 0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(negedge clk);
      check_eq("rel_ready", bus.cpu_ready, 1);
      check_eq("rel_mem_req", bus.mem_req, 0);
      @(posedge clk); #1;
      fetch(32'h0000_0300, 1'b0, 0, 32'h55AA_55AA, 1'b0);
      fetch(32'h0000_0300, 1'b1, 0, 32'h55AA_55AA, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
